// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for the multi-cycle ALU execution unit.
// The master is the decode/control side; the slave is the execution unit.
interface alu_exec_unit_if #(
    parameter int WIDTH = 64
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output op_valid,
        output operation,
        output a,
        output b,
        output res_ready,
        input  op_ready,
        input  res_valid,
        input  result,
        input  zero,
        input  illegal
    );

    modport slave (
        input  op_valid,
        input  operation,
        input  a,
        input  b,
        input  res_ready,
        output op_ready,
        output res_valid,
        output result,
        output zero,
        output illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit. ADD/SUB/AND/OR/SLT resolve on the accept
// edge; SLL walks one bit position per cycle so only a 1-bit shifter exists.
// Every handshake output comes straight from a flop, so there is no
// combinational path from op_valid to op_ready or from res_ready to res_valid.
module alu_exec_unit #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_exec_unit_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;

    localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Single-cycle datapath: returns {illegal, result}. SLL only reaches
    // here with a zero shift amount, so it passes operand A through.
    function automatic logic [WIDTH:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0] r;
        case (op)
            OP_ADD:  r = {1'b0, x + y};
            OP_SUB:  r = {1'b0, x + ~y + VAL_ONE};
            OP_AND:  r = {1'b0, x & y};
            OP_OR:   r = {1'b0, x | y};
            OP_SLT:  r = {1'b0, {(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLL:  r = {1'b0, x};
            default: r = {1'b1, VAL_ZERO};
        endcase
        return r;
    endfunction

    // Zero flag derived from the value about to be registered as result.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == VAL_ZERO);
    endfunction

    logic [1:0]       state_r,     state_s;
    logic [WIDTH-1:0] shreg_r,     shreg_s;
    logic [SHW-1:0]   cnt_r,       cnt_s;
    logic [WIDTH-1:0] result_r,    result_s;
    logic             zero_r,      zero_s;
    logic             illegal_r,   illegal_s;
    logic             op_ready_r,  op_ready_s;
    logic             res_valid_r, res_valid_s;
    logic [WIDTH:0]   eval_s;
    logic [SHW-1:0]   shamt_s;

    // Next-state and datapath selection for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        cnt_s       = cnt_r;
        result_s    = result_r;
        zero_s      = zero_r;
        illegal_s   = illegal_r;
        op_ready_s  = op_ready_r;
        res_valid_s = res_valid_r;
        eval_s      = alu_eval(bus.operation, bus.a, bus.b);
        shamt_s     = bus.b[SHW-1:0];

        case (state_r)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    op_ready_s = 1'b0;
                    if ((bus.operation == OP_SLL) && (shamt_s != CNT_ZERO)) begin
                        shreg_s = bus.a;
                        cnt_s   = shamt_s;
                        state_s = ST_SHIFT;
                    end else begin
                        result_s    = eval_s[WIDTH-1:0];
                        illegal_s   = eval_s[WIDTH];
                        zero_s      = is_zero(eval_s[WIDTH-1:0]);
                        res_valid_s = 1'b1;
                        state_s     = ST_DONE;
                    end
                end else begin
                    op_ready_s = 1'b1;
                end
            end
            ST_SHIFT: begin
                shreg_s = shreg_r << 1;
                cnt_s   = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    result_s    = shreg_r << 1;
                    illegal_s   = 1'b0;
                    zero_s      = is_zero(shreg_r << 1);
                    res_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    res_valid_s = 1'b0;
                    op_ready_s  = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    res_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                op_ready_s  = 1'b1;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // State, operand and output registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            shreg_r     <= VAL_ZERO;
            cnt_r       <= CNT_ZERO;
            result_r    <= VAL_ZERO;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            op_ready_r  <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            cnt_r       <= cnt_s;
            result_r    <= result_s;
            zero_r      <= zero_s;
            illegal_r   <= illegal_s;
            op_ready_r  <= op_ready_s;
            res_valid_r <= res_valid_s;
        end
    end

    assign bus.op_ready  = op_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes reference-model
// expectations at issue time, an independent monitor checks every result
// handoff, latency, backpressure stability and op_ready behaviour.
module tb_alu_exec_unit;
    localparam int WIDTH = 64;
    localparam int SHW   = 6;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   outstanding = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic hold_rr = 1'b1;
    exp_t sb_q[$];

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus();

    alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level occupancy: one op in flight between accept and handoff.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) outstanding <= 0;
        else outstanding <= outstanding + ((bus.op_valid && bus.op_ready) ? 1 : 0)
                                        - ((bus.res_valid && bus.res_ready) ? 1 : 0);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference behaviour straight from the operation table.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        int   sh;
        sh    = int'(y[5:0]);
        e.ill = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            OP_ADD:  e.res = x + y;
            OP_SUB:  e.res = x - y;
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_SLT:  e.res = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            OP_SLL:  begin e.res = x << sh; e.lat = (sh == 0) ? 1 : 1 + sh; end
            default: begin e.res = 64'd0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.op_valid  = 1'b1;
        bus.operation = op;
        bus.a         = x;
        bus.b         = y;
        n = 0;
        while (!bus.op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.op_ready) begin
            check("issue_timeout", 64'(bus.op_ready), 64'd1);
        end else begin
            e     = model(op, x, y);
            e.acc = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.op_valid  = 1'b0;
        bus.operation = 4'($urandom);
        bus.a         = {$urandom, $urandom};
        bus.b         = {$urandom, $urandom};
    endtask

    // Consumer: random backpressure unless a test forces a stall.
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.res_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares against the scoreboard whenever a result is offered.
    initial begin
        logic        prev_v;
        logic        prev_hs;
        logic        prev_stall;
        logic [63:0] held_res;
        logic        held_zero;
        logic        held_ill;
        exp_t        e;
        prev_v = 1'b0; prev_hs = 1'b0; prev_stall = 1'b0;
        held_res = 64'd0; held_zero = 1'b0; held_ill = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                prev_v = 1'b0; prev_hs = 1'b0; prev_stall = 1'b0;
            end else begin
                check("op_ready", 64'(bus.op_ready), 64'(outstanding == 0));
                if (prev_hs) check("res_valid_drop", 64'(bus.res_valid), 64'd0);
                if (prev_stall) begin
                    check("hold_valid", 64'(bus.res_valid), 64'd1);
                    check("hold_result", bus.result, held_res);
                    check("hold_zero", 64'(bus.zero), 64'(held_zero));
                    check("hold_illegal", 64'(bus.illegal), 64'(held_ill));
                end
                if (bus.res_valid) begin
                    check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                    if (sb_q.size() > 0) begin
                        e = sb_q[0];
                        if (!prev_v) check("latency", 64'(cyc - e.acc), 64'(e.lat));
                        if (bus.res_ready) begin
                            check("result", bus.result, e.res);
                            check("zero", 64'(bus.zero), 64'(e.zero));
                            check("illegal", 64'(bus.illegal), 64'(e.ill));
                            void'(sb_q.pop_front());
                        end
                    end
                end
                prev_v     = bus.res_valid;
                prev_hs    = bus.res_valid && bus.res_ready;
                prev_stall = bus.res_valid && !bus.res_ready;
                held_res   = bus.result;
                held_zero  = bus.zero;
                held_ill   = bus.illegal;
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Main stimulus: reset, directed cases, backpressure, reset mid-shift, random.
    initial begin
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;
        reset_n       = 1'b0;
        bus.op_valid  = 1'b0;
        bus.operation = 4'd0;
        bus.a         = 64'd0;
        bus.b         = 64'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_op_ready", 64'(bus.op_ready), 64'd1);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        hold_rr = 1'b0;

        issue(OP_ADD, 64'd5, 64'd7);
        issue(OP_SUB, 64'd9, 64'd9);
        issue(OP_SUB, 64'd0, 64'd1);
        issue(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        issue(OP_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(OP_AND, 64'hF0, 64'h3C);
        issue(OP_OR, 64'hF0, 64'h3C);
        issue(OP_SLL, 64'd1, 64'd3);
        issue(OP_SLL, 64'd1, 64'd69);
        issue(OP_SLL, 64'hDEAD_BEEF_0123_4567, 64'd0);
        issue(OP_SLL, 64'h0000_0000_0000_0003, 64'd63);
        issue(4'b1111, 64'd123, 64'd456);
        drain();

        // Backpressure: result must hold and a new request must be ignored.
        hold_rr = 1'b1;
        issue(OP_ADD, 64'd2, 64'd3);
        bus.op_valid  = 1'b1;
        bus.operation = OP_OR;
        bus.a         = 64'd7;
        bus.b         = 64'd8;
        repeat (10) @(negedge clk);
        #1;
        check("bp_result", bus.result, 64'd5);
        check("bp_op_ready", 64'(bus.op_ready), 64'd0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        hold_rr      = 1'b0;
        drain();

        // Reset in the middle of a long shift.
        issue(OP_SLL, 64'd1, 64'd40);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_op_ready", 64'(bus.op_ready), 64'd1);
        check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("mid_rst_result", bus.result, 64'd0);
        check("mid_rst_zero", 64'(bus.zero), 64'd0);
        check("mid_rst_illegal", 64'(bus.illegal), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(OP_ADD, 64'd1, 64'd1);
        drain();

        // Randomised traffic across all codes and operand shapes.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 7))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_OR;
                4: op = OP_SLT;
                5, 6: op = OP_SLL;
                default: begin
                    op = 4'($urandom_range(9, 15));
                    if (op == 4'd9) op = 4'b0011;
                end
            endcase
            x = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = 64'($urandom_range(0, 70));
                2: y = ~x;
                default: y = {$urandom, $urandom};
            endcase
            issue(op, x, y);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
